// File: rtl/mpu_ram_loader.sv
// Program loader: scatters a burst of 48-bit instruction words into eight byte-wide, interleaved RAM banks.
// Optional macro MPU_LOADER_BOUNDS_CHECK_EN: suppress writes of words crossing 0x7FFF and raise sticky err_o.
module mpu_ram_loader #(
    parameter int COUNT_W = 12
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic               start_i,
    input  logic [14:0]        base_i,
    input  logic [COUNT_W-1:0] count_i,
    input  logic [47:0]        w_dat_i,
    input  logic               w_stb_i,
    output logic               w_ack_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               err_o,
    output logic               ram_we_0_o,
    output logic               ram_we_1_o,
    output logic               ram_we_2_o,
    output logic               ram_we_3_o,
    output logic               ram_we_4_o,
    output logic               ram_we_5_o,
    output logic               ram_we_6_o,
    output logic               ram_we_7_o,
    output logic [11:0]        ram_adr_0_o,
    output logic [11:0]        ram_adr_1_o,
    output logic [11:0]        ram_adr_2_o,
    output logic [11:0]        ram_adr_3_o,
    output logic [11:0]        ram_adr_4_o,
    output logic [11:0]        ram_adr_5_o,
    output logic [11:0]        ram_adr_6_o,
    output logic [11:0]        ram_adr_7_o,
    output logic [7:0]         ram_dat_0_o,
    output logic [7:0]         ram_dat_1_o,
    output logic [7:0]         ram_dat_2_o,
    output logic [7:0]         ram_dat_3_o,
    output logic [7:0]         ram_dat_4_o,
    output logic [7:0]         ram_dat_5_o,
    output logic [7:0]         ram_dat_6_o,
    output logic [7:0]         ram_dat_7_o
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH, S_DONE} state_e;

    state_e             state_q, state_d;
    logic [14:0]        addr_q, addr_d;
    logic [COUNT_W-1:0] rem_q, rem_d;
    logic [7:0]         we_q, we_d;
    logic [7:0][11:0]   adr_q, adr_d;
    logic [7:0][7:0]    dat_q, dat_d;
    logic [5:0][14:0]   badr;
    logic               ack, xfer, oor;

    assign ack  = (state_q == S_LOAD) && (rem_q != '0);
    assign xfer = w_stb_i && ack;

`ifdef MPU_LOADER_BOUNDS_CHECK_EN
    logic err_q;
    // a + 5 > 0x7FFF  <=>  a > 0x7FFA
    assign oor   = (addr_q > 15'h7FFA);
    assign err_o = err_q;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            err_q <= 1'b0;
        end else if ((state_q == S_IDLE) && start_i) begin
            err_q <= 1'b0;
        end else if (xfer && oor) begin
            err_q <= 1'b1;
        end
    end
`else
    assign oor   = 1'b0;
    assign err_o = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    addr_d  = base_i;
                    rem_d   = count_i;
                    state_d = (count_i == '0) ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: begin
                if (xfer) begin
                    addr_d = addr_q + 15'd6;
                    rem_d  = rem_q - 1'b1;
                    if (rem_q == COUNT_W'(1)) state_d = S_FLUSH;
                end
            end
            S_FLUSH: state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    // Byte addresses of the six bytes of the word being accepted; wrap falls out of the 15-bit add.
    always_comb begin
        for (int j = 0; j < 6; j++) begin
            badr[j] = addr_q + 15'(j);
        end
    end

    always_comb begin
        we_d  = '0;
        adr_d = adr_q;
        dat_d = dat_q;
        if (xfer && !oor) begin
            for (int j = 0; j < 6; j++) begin
                we_d[badr[j][2:0]]  = 1'b1;
                adr_d[badr[j][2:0]] = badr[j][14:3];
                dat_d[badr[j][2:0]] = w_dat_i[8*j +: 8];
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            we_q    <= '0;
            adr_q   <= '0;
            dat_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
        end
    end

    assign w_ack_o = ack;
    assign busy_o  = (state_q != S_IDLE);
    assign done_o  = (state_q == S_DONE);

    assign ram_we_0_o  = we_q[0];
    assign ram_we_1_o  = we_q[1];
    assign ram_we_2_o  = we_q[2];
    assign ram_we_3_o  = we_q[3];
    assign ram_we_4_o  = we_q[4];
    assign ram_we_5_o  = we_q[5];
    assign ram_we_6_o  = we_q[6];
    assign ram_we_7_o  = we_q[7];
    assign ram_adr_0_o = adr_q[0];
    assign ram_adr_1_o = adr_q[1];
    assign ram_adr_2_o = adr_q[2];
    assign ram_adr_3_o = adr_q[3];
    assign ram_adr_4_o = adr_q[4];
    assign ram_adr_5_o = adr_q[5];
    assign ram_adr_6_o = adr_q[6];
    assign ram_adr_7_o = adr_q[7];
    assign ram_dat_0_o = dat_q[0];
    assign ram_dat_1_o = dat_q[1];
    assign ram_dat_2_o = dat_q[2];
    assign ram_dat_3_o = dat_q[3];
    assign ram_dat_4_o = dat_q[4];
    assign ram_dat_5_o = dat_q[5];
    assign ram_dat_6_o = dat_q[6];
    assign ram_dat_7_o = dat_q[7];

endmodule

// File: doc/mpu_ram_loader.md
# mpu_ram_loader

Program loader for the MPU instruction store: the write-side counterpart of the instruction fetch path that reads 48-bit instructions from eight byte-wide RAM banks at arbitrary byte addresses. It accepts a burst of 48-bit instruction words over a valid/ack handshake, starting at any byte address, and scatters each word's six bytes into the interleaved banks. Byte address A lives in bank A mod 8 at row A >> 3. It sits between the host/debug program-load port and the write ports of the eight instruction RAM banks.

## Interface
- COUNT_W, 12, width of the word-count input and internal remaining counter
- sys_clk  in  1  system clock, all logic rising-edge
- sys_rst_n  in  1  asynchronous active-low reset
- start_i  in  1  begin a burst; sampled only in IDLE
- base_i  in  15  byte address of the first word's least-significant byte; latched on start
- count_i  in  COUNT_W  number of 48-bit words in the burst; latched on start
- w_dat_i  in  48  instruction word; byte j = bits [8j+7:8j]
- w_stb_i  in  1  w_dat_i valid
- w_ack_o  out  1  word accepted this cycle (transfer = w_stb_i & w_ack_o)
- busy_o  out  1  burst in progress
- done_o  out  1  one-cycle pulse at burst end
- err_o  out  1  sticky out-of-range flag (only with MPU_LOADER_BOUNDS_CHECK_EN, else tied 0)
- ram_we_k_o  out  1  write enable of bank k, k = 0..7 (eight ports)
- ram_adr_k_o  out  12  row address of bank k (eight ports)
- ram_dat_k_o  out  8  write data of bank k (eight ports)

## Operation
- States: IDLE, LOAD, FLUSH, DONE.
- IDLE: start_i=1 latches base_i into addr register and count_i into remaining.
  - Goes to LOAD, or to DONE when count_i=0.
  - Clears err_o.
- LOAD: w_ack_o = (remaining != 0).
  - On each transfer, register the word and its address into the write stage.
  - addr += 6, modulo 2^15.
  - remaining -= 1.
  - A transfer that brings remaining to 0 moves the FSM to FLUSH.
- FLUSH: the last word's write stage fires. Next state is DONE.
- DONE: done_o=1 for one cycle, then IDLE.
- Write stage for a word registered with address a:
  - For j = 0..5, byte j goes to byte address b = (a + j) mod 2^15.
  - Bank b[2:0] gets ram_we=1, ram_adr=b[14:3], ram_dat=byte j.
  - The two banks not covered get ram_we=0; their adr and dat hold their previous values.
  - Exactly six ram_we bits are high per written word.
- start_i outside IDLE is ignored.
- w_stb_i outside LOAD is ignored; w_ack_o=0 there.
- w_dat_i must be held while w_stb_i=1 and w_ack_o=0.

## Timing
- Reset values: every output 0, all ram_adr/ram_dat 0, state IDLE.
  - Any pending write-stage word is dropped; no ram_we is asserted after reset deasserts until a new transfer.
- start at cycle t → busy_o=1 and LOAD at t+1; first possible transfer at t+1.
- Transfer at cycle n → ram_we/adr/dat driven during cycle n+1 (one-cycle latency).
- Full throughput: one word per cycle while w_stb_i stays high.
- Last transfer at n → writes at n+1 (FLUSH) → done_o at n+2.
  - busy_o stays high through the done_o cycle and falls at n+3.
- count_i=0: start at t → done_o at t+1, no writes.
- Address wrap: a word whose six bytes cross 0x7FFF continues at byte 0, and the row wraps to 0.
- Back-to-back bursts: start_i is honoured the cycle after done_o, once the FSM is back in IDLE.

## Configuration
- MPU_LOADER_BOUNDS_CHECK_EN defined: a word with a + 5 > 0x7FFF is acked and the address advances, but no ram_we is asserted for it.
  - err_o sets the cycle after such a transfer and stays set until the next accepted start.
- Undefined: addresses wrap modulo 2^15 as above, and err_o is constant 0.

## Test plan
- Aligned single word: base=0x0000, count=1, word 0x665544332211.
  - Required: one cycle later banks 0..5 write 11,22,33,44,55,66 at row 0; banks 6,7 we=0; done_o two cycles after the transfer.
- Unaligned word: base=0x0005, word 0x0C0B0A090807.
  - Required: bank5 row0=07, bank6 row0=08, bank7 row0=09, bank0 row1=0A, bank1 row1=0B, bank2 row1=0C.
- Streaming burst: base=0x0003, count=4, w_stb_i held high.
  - Required: w_ack_o high four consecutive cycles; addresses used 0x03, 0x09, 0x0F, 0x15; 24 contiguous bytes land correctly; busy_o deasserts after done_o.
- Stalled producer: w_stb_i low for 3 cycles mid-burst.
  - Required: no ram_we during the gap; remaining count and addr unchanged; done_o only after the final word.
- Wrap/bounds: base=0x7FFD, count=1.
  - Without macro: bytes land at 0x7FFD..0x7FFF and 0x0000..0x0002.
  - With MPU_LOADER_BOUNDS_CHECK_EN: no ram_we, err_o=1 until the next start.
- Reset mid-burst: assert sys_rst_n=0 one cycle after a transfer.
  - Required: all outputs 0 immediately; no write after release; start_i then works normally; count=0 start yields done_o at t+1.
